jtopl_wrctl: RTL and testbench

- CPU-side register write controller for the OPL core.
- Accepts bus address/data writes and decodes the OPL2 register map into the strobes consumed by the operator/channel register block: up_*, sel_group, sel_sub, write and the data byte.
- Holds each decoded operator/channel update stable for one full 18-slot sweep, so the rotating slot counter is guaranteed to hit the target slot.
- Also owns the global registers: rhythm, CSM/NTS and wave enable.

---
 rtl/jtopl_wrctl.sv | 176 +++++++++++++++++
 tb/tb_jtopl_wrctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_wrctl.sv
// jtopl_wrctl: CPU write controller for the OPL core.
// Decodes the OPL2 register map into operator/channel update strobes and holds
// each update for a full slot sweep. It also owns the rhythm, CSM/NTS and
// wave-enable global registers.
module jtopl_wrctl #(
  parameter int unsigned HOLD = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       write,
  output logic [7:0] dout,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       rhy_en,
  output logic [4:0] rhy_kon,
  output logic       csm,
  output logic       nts,
  output logic       wave_en
);

  localparam int unsigned CW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned NUP = 7;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t         state;
  logic           acc_l;
  logic [7:0]     addr_q;
  logic [CW-1:0]  cnt;
  logic [NUP-1:0] up_q;

  logic           acc_c;
  logic           stb_c;
  logic           awr_c;
  logic           dwr_c;
  logic [4:0]     op_c;
  logic [3:0]     ch_c;
  logic           dec_ok_c;
  logic [NUP-1:0] dec_up_c;
  logic [1:0]     dec_grp_c;
  logic [2:0]     dec_sub_c;

  assign acc_c = !cs_n && !wr_n;
  assign stb_c = acc_c && !acc_l;
  assign awr_c = stb_c && !addr;
  assign dwr_c = stb_c && addr;
  assign op_c  = addr_q[4:0];
  assign ch_c  = addr_q[3:0];

  // Bit order: mult, ksl_tl, ar_dr, sl_rr, fnumlo, fnumhi, fbcon
  assign {up_fbcon, up_fnumhi, up_fnumlo, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult} = up_q;

  // Access edge detector and address latch (address writes are taken even while busy)
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l  <= 1'b0;
      addr_q <= 8'd0;
    end else begin
      acc_l <= acc_c;
      if (awr_c) addr_q <= din;
    end
  end

  // Decode the latched address into an operator or channel target
  always_comb begin
    dec_ok_c  = 1'b0;
    dec_up_c  = '0;
    dec_grp_c = 2'd0;
    dec_sub_c = 3'd0;
    case (addr_q[7:4])
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        // Subslots 6/7 and offsets 0x16 and above are holes
        dec_ok_c  = (op_c[2:1] != 2'b11) && (op_c[4:3] != 2'b11);
        dec_grp_c = op_c[4:3];
        dec_sub_c = op_c[2:0];
        case (addr_q[7:5])
          3'd1:    dec_up_c = NUP'(7'b000_0001);
          3'd2:    dec_up_c = NUP'(7'b000_0010);
          3'd3:    dec_up_c = NUP'(7'b000_0100);
          default: dec_up_c = NUP'(7'b000_1000);
        endcase
      end
      4'hA, 4'hB, 4'hC: begin
        dec_ok_c  = (ch_c <= 4'd8);
        dec_grp_c = 2'(ch_c / 4'd3);
        dec_sub_c = 3'(ch_c % 4'd3);
        case (addr_q[5:4])
          2'd2:    dec_up_c = NUP'(7'b001_0000);
          2'd3:    dec_up_c = NUP'(7'b010_0000);
          default: dec_up_c = NUP'(7'b100_0000);
        endcase
      end
      default: ;
    endcase
  end

  // Update FSM: start a held operator/channel update, then count cen ticks down
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      write     <= 1'b0;
      dout      <= 8'd0;
      sel_group <= 2'd0;
      sel_sub   <= 3'd0;
      up_q      <= '0;
    end else begin
      write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dwr_c && dec_ok_c) begin
            dout      <= din;
            sel_group <= dec_grp_c;
            sel_sub   <= dec_sub_c;
            up_q      <= dec_up_c;
            write     <= 1'b1;
            busy      <= 1'b1;
            cnt       <= CW'(HOLD - 1);
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cen) begin
            if (cnt == '0) begin
              up_q  <= '0;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Global registers: written directly, no hold and no write pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rhy_en  <= 1'b0;
      rhy_kon <= 5'd0;
      csm     <= 1'b0;
      nts     <= 1'b0;
      wave_en <= 1'b0;
    end else if (dwr_c && state == ST_IDLE) begin
      case (addr_q)
        8'hBD: begin
          rhy_en  <= din[5];
          rhy_kon <= din[4:0];
        end
        8'h08: begin
          csm <= din[7];
          nts <= din[6];
        end
        8'h01: wave_en <= din[5];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrctl.sv
// Bench for jtopl_wrctl: directed bus writes, a cycle-level reference model
// and per-cycle comparison of every output, plus literal spot checks.
`timescale 1ns/1ps
module tb_jtopl_wrctl;

  localparam int HOLD = 18;

  logic       clk = 1'b0;
  logic       rst, cen, cs_n, wr_n, addr;
  logic [7:0] din;
  logic       busy, write;
  logic [7:0] dout;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnumlo, up_fnumhi, up_fbcon;
  logic       rhy_en, csm, nts, wave_en;
  logic [4:0] rhy_kon;

  jtopl_wrctl #(.HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .busy(busy), .write(write), .dout(dout), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
    .rhy_en(rhy_en), .rhy_kon(rhy_kon), .csm(csm), .nts(nts), .wave_en(wave_en)
  );

  always #5 clk = ~clk;

  // cen generator: one pulse every cen_period clocks
  int cen_period = 1;
  int cdiv = 0;
  always @(negedge clk) begin
    cdiv = (cdiv + 1) % cen_period;
    cen  = (cdiv == 0);
  end

  // Count write pulses seen on the output
  int n_wp = 0;
  always @(negedge clk) if (write === 1'b1) n_wp++;

  // Reference model. up bit k: 0 mult,1 ksl_tl,2 ar_dr,3 sl_rr,4 fnumlo,5 fnumhi,6 fbcon
  logic       m_prev, m_busy, m_write, m_rhy_en, m_csm, m_nts, m_wave;
  logic [7:0] m_addr, m_dout;
  logic [1:0] m_grp;
  logic [2:0] m_sub;
  logic [6:0] m_up;
  logic [4:0] m_rhy_kon;
  int         m_cens;

  always @(posedge clk) begin : model
    logic acc, rise, was_busy, ok;
    int hi, o, ch, kind, grp, sub;
    acc = (cs_n === 1'b0) && (wr_n === 1'b0);
    m_write = 1'b0;
    if (rst) begin
      m_prev = 0; m_addr = 0; m_busy = 0; m_cens = 0; m_dout = 0; m_grp = 0; m_sub = 0;
      m_up = 0; m_rhy_en = 0; m_rhy_kon = 0; m_csm = 0; m_nts = 0; m_wave = 0;
    end else begin
      rise = acc && !m_prev;
      m_prev = acc;
      was_busy = m_busy;
      if (m_busy && cen) begin
        m_cens++;
        if (m_cens == HOLD) begin m_busy = 0; m_up = 0; end
      end
      if (rise && !addr) m_addr = din;
      else if (rise && !was_busy) begin
        hi = m_addr / 16; ok = 0; kind = 0; grp = 0; sub = 0;
        if (hi >= 2 && hi <= 9) begin
          o = m_addr % 32; kind = (hi - 2) / 2; grp = o / 8; sub = o % 8;
          ok = (sub < 6) && (o < 'h16);
        end else if (hi >= 10 && hi <= 12) begin
          ch = m_addr % 16; kind = 4 + hi - 10; grp = ch / 3; sub = ch % 3;
          ok = (ch <= 8);
        end
        if (ok) begin
          m_busy = 1; m_write = 1; m_cens = 0; m_dout = din;
          m_grp = 2'(grp); m_sub = 3'(sub); m_up = 7'(1 << kind);
        end else if (m_addr == 8'hBD) begin
          m_rhy_en = din[5]; m_rhy_kon = din[4:0];
        end else if (m_addr == 8'h08) begin
          m_csm = din[7]; m_nts = din[6];
        end else if (m_addr == 8'h01) begin
          m_wave = din[5];
        end
      end
    end
  end

  logic [6:0]  dut_up;
  logic [30:0] dut_v, mdl_v;
  assign dut_up = {up_fbcon, up_fnumhi, up_fnumlo, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
  assign dut_v  = {busy, write, dout, sel_group, sel_sub, dut_up, rhy_en, rhy_kon, csm, nts, wave_en};
  assign mdl_v  = {m_busy, m_write, m_dout, m_grp, m_sub, m_up, m_rhy_en, m_rhy_kon, m_csm, m_nts, m_wave};

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model
  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (chk_en) chk("cycle", 32'(dut_v), 32'(mdl_v));
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    chk(nm, 32'(busy), 32'd0);
  endtask

  // Length of the busy window, cen ticks inside it, and cycles where up_* moved
  task automatic measure(output int n, output int c, output int moved);
    logic [6:0] up0;
    up0 = dut_up; n = 0; c = 0; moved = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      if (dut_up !== up0) moved++;
      #1;
      if (cen === 1'b1) c++;
      @(negedge clk);
    end
  endtask

  int n, c, moved, wp0;

  initial begin
    rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = 8'd0;
    fork cmp_loop(); join_none
    @(negedge clk); chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(dut_v), 32'd0);
    rst = 1'b0;

    // Operator write 0x43 <- 0x3F, cen every clk
    wr(1'b0, 8'h43); wr(1'b1, 8'h3F);
    chk("t1_write", 32'(write), 32'd1);
    chk("t1_up", 32'(dut_up), 32'h02);
    chk("t1_grp", 32'(sel_group), 32'd0);
    chk("t1_sub", 32'(sel_sub), 32'd3);
    chk("t1_dout", 32'(dout), 32'h3F);
    measure(n, c, moved);
    chk("t1_len", 32'(n), 32'd18);
    chk("t1_cens", 32'(c), 32'd18);
    chk("t1_stable", 32'(moved), 32'd0);
    chk("t1_up_clr", 32'(dut_up), 32'd0);

    // Channel write 0xB7 <- 0x2D, then a dropped data write and an address write in HOLD
    wp0 = n_wp;
    wr(1'b0, 8'hB7); wr(1'b1, 8'h2D);
    chk("t2_up", 32'(dut_up), 32'h20);
    chk("t2_grp", 32'(sel_group), 32'd2);
    chk("t2_sub", 32'(sel_sub), 32'd1);
    chk("t2_dout", 32'(dout), 32'h2D);
    repeat (3) @(negedge clk);
    wr(1'b1, 8'h11);
    chk("t2_drop_wr", 32'(write), 32'd0);
    chk("t2_drop_dout", 32'(dout), 32'h2D);
    wr(1'b0, 8'hC4);
    wait_idle("t2_idle");
    wr(1'b1, 8'h07);
    chk("t2_c4_up", 32'(dut_up), 32'h40);
    chk("t2_c4_grp", 32'(sel_group), 32'd1);
    chk("t2_c4_sub", 32'(sel_sub), 32'd1);
    wait_idle("t2_idle2");
    chk("t2_pulses", 32'(n_wp - wp0), 32'd2);

    // Holes: operator sub 6 and channel 9
    wr(1'b0, 8'h26); wr(1'b1, 8'h55);
    chk("t3_26", 32'({busy, write, dut_up}), 32'd0);
    wr(1'b0, 8'hA9); wr(1'b1, 8'h55);
    chk("t3_a9", 32'({busy, write, dut_up}), 32'd0);

    // Global registers
    wr(1'b0, 8'hBD); wr(1'b1, 8'h3F);
    chk("t4_rhy", 32'({busy, write, rhy_en, rhy_kon}), 32'h3F);
    wr(1'b0, 8'h08); wr(1'b1, 8'hC0);
    chk("t4_csm_nts", 32'({busy, csm, nts}), 32'h3);
    wr(1'b0, 8'h01); wr(1'b1, 8'h20);
    chk("t4_wave", 32'({busy, wave_en}), 32'h1);

    // Slow cen: hold spans 18 cen ticks
    @(negedge clk); cen_period = 3;
    wr(1'b0, 8'h80); wr(1'b1, 8'h12);
    chk("t5_up", 32'(dut_up), 32'h08);
    chk("t5_dout", 32'(dout), 32'h12);
    measure(n, c, moved);
    chk("t5_cens", 32'(c), 32'd18);
    chk("t5_len", 32'(n >= 52 && n <= 54), 32'd1);
    chk("t5_stable", 32'(moved), 32'd0);
    chk("t5_up_clr", 32'(dut_up), 32'd0);
    cen_period = 1;

    // Reset during HOLD
    wr(1'b0, 8'h60); wr(1'b1, 8'h44);
    chk("t6_up", 32'({busy, dut_up}), 32'h84);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_abort", 32'(dut_v), 32'd0);
    rst = 1'b0;
    wr(1'b1, 8'h77);
    chk("t6_after", 32'({busy, write, dut_up}), 32'd0);

    // Data write landing on the clock where HOLD ends is dropped
    wr(1'b0, 8'h2A); wr(1'b1, 8'h5A);
    chk("t7_up", 32'(dut_up), 32'h01);
    chk("t7_grp_sub", 32'({sel_group, sel_sub}), 32'h0A);
    repeat (17) @(negedge clk);
    chk("t7_last_busy", 32'(busy), 32'd1);
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h99;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    chk("t7_end", 32'({busy, write, dout}), 32'h05A);
    wr(1'b1, 8'h66);
    chk("t7_next", 32'({busy, write, dout}), 32'h366);
    wait_idle("t7_idle");

    // Strobe held low across reset release counts as a new access
    @(negedge clk);
    rst = 1'b1; cs_n = 1'b0; wr_n = 1'b0; addr = 1'b0; din = 8'h21;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;
    wr(1'b1, 8'h4C);
    chk("t9_wr", 32'({write, dut_up}), 32'h81);
    chk("t9_sel", 32'({sel_group, sel_sub, dout}), 32'h14C);
    wait_idle("t9_idle");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
